// File: rtl/gpia_port_if.sv
// Bus-side signals of the GPIA port: register write strobes, data and readback.
interface gpia_port_if #(
  parameter int WIDTH = 64
);
  logic                 we_i;
  logic [1:0]           reg_i;
  logic [1:0]           mode_i;
  logic [WIDTH/8-1:0]   stb_i;
  logic [WIDTH-1:0]     d_i;
  logic [WIDTH-1:0]     dat_o;

  modport master (output we_i, reg_i, mode_i, stb_i, d_i, input dat_o);
  modport slave  (input we_i, reg_i, mode_i, stb_i, d_i, output dat_o);
endinterface

// File: rtl/gpia_port.sv
// GPIA port: lane-strobed output register with write/set/clear/toggle, synchronised inputs with
// polarity-selectable edge capture (W1C). Define GPIA_IRQ_EN to add the IEN register and irq_o.
module gpia_port #(
  parameter int WIDTH = 64,
  parameter int LANES = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             res_i,
  gpia_port_if.slave       bus,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] s1, s2, prev;
  logic [WIDTH-1:0] edge_st, pol, ien;
  logic [WIDTH-1:0] bmask, dm, q_nxt, ev, w1c;
  logic             wr;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < LANES; k++) begin
      bmask[8*k +: 8] = {8{bus.stb_i[k]}};
    end
  end

  assign wr = bus.we_i & (|bus.stb_i);
  assign dm = bus.d_i & bmask;

  always_comb begin
    q_nxt = q_o;
    case (bus.mode_i)
      2'd0: q_nxt = (q_o & ~bmask) | dm;
      2'd1: q_nxt = q_o | dm;
      2'd2: q_nxt = q_o & ~dm;
      2'd3: q_nxt = q_o ^ dm;
      default: q_nxt = q_o;
    endcase
  end

  // Detection looks only at s2 vs prev, so a POL write never fabricates an event.
  assign ev  = (pol & s2 & ~prev) | (~pol & ~s2 & prev);
  assign w1c = (wr && bus.reg_i == 2'd1) ? dm : '0;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      edge_st   <= '0;
      pol       <= '0;
      q_o       <= '0;
      bus.dat_o <= '0;
    end else begin
      s1   <= pin_i;
      s2   <= s1;
      prev <= s2;
      // A new event outranks a same-cycle clear.
      edge_st <= (edge_st & ~w1c) | ev;
      if (wr && bus.reg_i == 2'd0) q_o <= q_nxt;
      if (wr && bus.reg_i == 2'd2) pol <= (pol & ~bmask) | dm;
      case (bus.reg_i)
        2'd0:    bus.dat_o <= q_o;
        2'd1:    bus.dat_o <= edge_st;
        2'd2:    bus.dat_o <= pol;
        default: bus.dat_o <= ien;
      endcase
    end
  end

`ifdef GPIA_IRQ_EN
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      ien   <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr && bus.reg_i == 2'd3) ien <= (ien & ~bmask) | dm;
      irq_o <= |(edge_st & ien);
    end
  end
`else
  assign ien   = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpia_port.sv
// Self-checking bench for gpia_port (WIDTH=64): per-cycle model compare plus directed literal checks.
module tb_gpia_port;
  localparam int W = 64;

  logic         clk_i = 1'b0;
  logic         res_i = 1'b0;
  logic [W-1:0] pin_i = '0;
  logic [W-1:0] q_o;
  logic         irq_o;
  int           errors = 0;
  int           checks = 0;

  gpia_port_if #(.WIDTH(W)) bus ();

  gpia_port #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .res_i (res_i),
    .bus   (bus),
    .pin_i (pin_i),
    .q_o   (q_o),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef GPIA_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: registers as plain arrays, pins as a sample history.
  logic [W-1:0] m_q, m_edge, m_pol, m_ien, m_dat;
  logic         m_irq;
  logic [W-1:0] hist [3];

  always @(posedge clk_i or negedge res_i) begin
    logic [W-1:0] nq, ne, np, ni;
    logic         lane_on, seen_now, seen_before, happened;
    if (!res_i) begin
      m_q = '0; m_edge = '0; m_pol = '0; m_ien = '0; m_dat = '0; m_irq = 1'b0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
    end else begin
      case (bus.reg_i)
        2'd0: m_dat = m_q;
        2'd1: m_dat = m_edge;
        2'd2: m_dat = m_pol;
        default: m_dat = m_ien;
      endcase
      m_irq = IRQ_ON && ((m_edge & m_ien) != '0);
      nq = m_q; ne = m_edge; np = m_pol; ni = m_ien;
      for (int b = 0; b < W; b++) begin
        lane_on = bus.we_i && bus.stb_i[b/8];
        if (lane_on && bus.reg_i == 2'd0) begin
          case (bus.mode_i)
            2'd0: nq[b] = bus.d_i[b];
            2'd1: nq[b] = m_q[b] | bus.d_i[b];
            2'd2: nq[b] = m_q[b] & ~bus.d_i[b];
            default: nq[b] = m_q[b] ^ bus.d_i[b];
          endcase
        end
        if (lane_on && bus.reg_i == 2'd2) np[b] = bus.d_i[b];
        if (IRQ_ON && lane_on && bus.reg_i == 2'd3) ni[b] = bus.d_i[b];
        if (lane_on && bus.reg_i == 2'd1 && bus.d_i[b]) ne[b] = 1'b0;
        seen_now    = hist[1][b];
        seen_before = hist[2][b];
        happened    = m_pol[b] ? (seen_now && !seen_before) : (!seen_now && seen_before);
        if (happened) ne[b] = 1'b1;
      end
      m_q = nq; m_edge = ne; m_pol = np; m_ien = ni;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pin_i;
    end
  end

  always @(negedge clk_i) begin
    if (res_i === 1'b1) begin
      chk("model q_o", q_o, m_q);
      chk("model dat_o", bus.dat_o, m_dat);
      chk("model irq_o", {63'd0, irq_o}, {63'd0, m_irq});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [1:0] md, input logic [7:0] s, input logic [W-1:0] d);
    bus.we_i = 1'b1; bus.reg_i = r; bus.mode_i = md; bus.stb_i = s; bus.d_i = d;
    step(1);
    bus.we_i = 1'b0;
  endtask

  initial begin
    bus.we_i = 1'b0; bus.reg_i = 2'd0; bus.mode_i = 2'd0; bus.stb_i = '0; bus.d_i = '0;
    #23;
    chk("reset q_o", q_o, '0);
    chk("reset dat_o", bus.dat_o, '0);
    chk("reset irq_o", {63'd0, irq_o}, '0);
    step(1);
    res_i = 1'b1;
    step(2);

    wr(2'd0, 2'd0, 8'b0000_1100, 64'h3C3C3C3C3C3C3C3C);
    chk("lane write", q_o, 64'h000000003C3C0000);
    wr(2'd0, 2'd3, 8'b0000_0100, {W{1'b1}});
    chk("lane toggle", q_o, 64'h000000003CC30000);
    wr(2'd0, 2'd0, 8'hFF, '0);
    chk("clear all", q_o, '0);
    wr(2'd0, 2'd1, 8'hFF, 64'h0F0F0F0F0F0F0F0F);
    chk("set", q_o, 64'h0F0F0F0F0F0F0F0F);
    wr(2'd0, 2'd2, 8'h01, 64'h0303030303030303);
    chk("clear lane0", q_o, 64'h0F0F0F0F0F0F0F0C);
    bus.reg_i = 2'd0;
    step(1);
    chk("read OUT", bus.dat_o, 64'h0F0F0F0F0F0F0F0C);

    wr(2'd2, 2'd0, 8'h01, 64'h20);
    wr(2'd3, 2'd0, 8'h01, 64'h20);
    pin_i[5] = 1'b1;
    bus.reg_i = 2'd1;
    step(3);
    chk("edge not yet visible", bus.dat_o, '0);
    step(1);
    chk("edge captured", bus.dat_o, 64'h20);
    chk("irq raised", {63'd0, irq_o}, {63'd0, IRQ_ON});
    wr(2'd1, 2'd0, 8'h01, 64'h20);
    step(1);
    chk("w1c edge", bus.dat_o, '0);
    chk("w1c irq", {63'd0, irq_o}, '0);

    pin_i[5] = 1'b0;
    step(4);
    pin_i[5] = 1'b1;
    step(2);
    bus.we_i = 1'b1; bus.reg_i = 2'd1; bus.stb_i = 8'h01; bus.d_i = 64'h20;
    step(1);
    bus.we_i = 1'b0;
    step(1);
    chk("race edge", bus.dat_o, 64'h20);
    chk("race irq", {63'd0, irq_o}, {63'd0, IRQ_ON});

    wr(2'd2, 2'd0, 8'hFF, 64'h123456789ABCDEF0);
    pin_i[0] = 1'b1;
    step(4);
    wr(2'd1, 2'd0, 8'hFF, {W{1'b1}});
    pin_i[0] = 1'b0;
    bus.reg_i = 2'd1;
    step(5);
    chk("falling edge", bus.dat_o, 64'h01);
    chk("falling irq", {63'd0, irq_o}, '0);
    bus.reg_i = 2'd2;
    step(1);
    chk("read POL", bus.dat_o, 64'h123456789ABCDEF0);
    bus.reg_i = 2'd3;
    step(1);
    chk("read IEN", bus.dat_o, IRQ_ON ? 64'h20 : 64'h0);

    wr(2'd3, 2'd0, 8'hFF, {W{1'b1}});
    wr(2'd0, 2'd0, 8'hFF, {W{1'b1}});
    bus.reg_i = 2'd0;
    step(2);
    chk("pre-reset q_o", q_o, {W{1'b1}});
    chk("pre-reset irq", {63'd0, irq_o}, {63'd0, IRQ_ON});
    #2;
    res_i = 1'b0;
    #1;
    chk("async reset q_o", q_o, '0);
    chk("async reset dat_o", bus.dat_o, '0);
    chk("async reset irq", {63'd0, irq_o}, '0);
    step(2);
    res_i = 1'b1;
    step(4);
    chk("post-reset q_o", q_o, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
